// File: rtl/mem_arb_pkg.sv
// Shared state encoding and sizing helpers for the multi-channel miss arbiter.
package mem_arb_pkg;

  typedef logic [2:0] state_t;

  localparam state_t S_IDLE  = 3'd0;
  localparam state_t S_ISSUE = 3'd1;
  localparam state_t S_DRAIN = 3'd2;
  localparam state_t S_WRITE = 3'd3;
  localparam state_t S_DONE  = 3'd4;

  function automatic int bytes_per_word(input int dw);
    return dw / 8;
  endfunction

  // Block offset bits: everything below the block base address.
  function automatic int offs_bits(input int words, input int dw);
    return $clog2(words * (dw / 8));
  endfunction

  function automatic int idx_bits(input int words);
    return $clog2(words);
  endfunction

  // A single channel still needs a 1-bit index/pointer.
  function automatic int ch_bits(input int n_ch);
    return (n_ch > 1) ? $clog2(n_ch) : 1;
  endfunction

endpackage

// File: rtl/mem_miss_arbiter_rr.sv
// Combinational round-robin pick: first requester at or after the pointer.
module rr_arbiter #(
  parameter int N_CH    = 2,
  parameter int CH_BITS = 1
) (
  input  logic [N_CH-1:0]    req_i,
  input  logic [CH_BITS-1:0] ptr_i,
  output logic [N_CH-1:0]    gnt_o,
  output logic [CH_BITS-1:0] idx_o
);

  logic found;

  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    found = 1'b0;
    for (int i = 0; i < N_CH; i++) begin
      int                 c_int;
      logic [CH_BITS-1:0] cand;
      c_int = int'(ptr_i) + i;
      if (c_int >= N_CH) c_int = c_int - N_CH;
      cand = CH_BITS'(c_int);
      if (!found && req_i[cand]) begin
        found       = 1'b1;
        gnt_o[cand] = 1'b1;
        idx_o       = cand;
      end
    end
  end

endmodule

// File: rtl/mem_miss_arbiter.sv
// Round-robin steering of N cache block fills / write-throughs onto one pipelined
// fixed-latency memory. Fills issue one word address per cycle, back to back.
module mem_miss_arbiter
  import mem_arb_pkg::*;
#(
  parameter int N_CH    = 2,
  parameter int AW      = 16,
  parameter int DW      = 16,
  parameter int WORDS   = 8,
  parameter int MEM_LAT = 4
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic [N_CH-1:0]          ch_req_i,
  input  logic [N_CH-1:0]          ch_wr_i,
  input  logic [N_CH*AW-1:0]       ch_addr_i,
  input  logic [N_CH*DW-1:0]       ch_wdata_i,
  output logic [N_CH-1:0]          ch_grant_o,
  output logic                     ch_busy_o,
  output logic [N_CH-1:0]          ch_fill_valid_o,
  output logic [DW-1:0]            ch_fill_data_o,
  output logic [$clog2(WORDS)-1:0] ch_fill_idx_o,
  output logic [N_CH-1:0]          ch_done_o,
  output logic                     mem_enable_o,
  output logic                     mem_wr_o,
  output logic [AW-1:0]            mem_addr_o,
  output logic [DW-1:0]            mem_wdata_o,
  input  logic [DW-1:0]            mem_rdata_i,
  input  logic                     mem_data_valid_i
);

  localparam int BYTES_PER_WORD = bytes_per_word(DW);
  localparam int OFFS_BITS      = offs_bits(WORDS, DW);
  localparam int IDX_BITS       = idx_bits(WORDS);
  localparam int CH_BITS        = ch_bits(N_CH);
  localparam int WORD_SHIFT     = $clog2(BYTES_PER_WORD);

  localparam logic [AW-1:0]       OFFS_MASK = AW'((1 << OFFS_BITS) - 1);
  localparam logic [IDX_BITS-1:0] ISSUE_LAST = IDX_BITS'(WORDS - 1);
  localparam logic [IDX_BITS:0]   RECV_FULL  = (IDX_BITS + 1)'(WORDS);

  state_t               state_q, state_d;
  logic [CH_BITS-1:0]   owner_q, owner_d;
  logic [N_CH-1:0]      grant_q, grant_d;
  logic [AW-1:0]        addr_q, addr_d;
  logic [DW-1:0]        wdata_q, wdata_d;
  logic [IDX_BITS-1:0]  issue_cnt_q, issue_cnt_d;
  logic [IDX_BITS:0]    recv_cnt_q, recv_cnt_d;
  logic [CH_BITS-1:0]   rr_q, rr_d;
  logic [MEM_LAT-1:0]   pend_q, pend_d;

  logic [AW-1:0]        addr_arr  [N_CH];
  logic [DW-1:0]        wdata_arr [N_CH];
  logic [N_CH-1:0]      arb_gnt;
  logic [CH_BITS-1:0]   arb_idx;
  logic                 issue_rd;
  logic                 fill_strobe;

  for (genvar g = 0; g < N_CH; g++) begin : g_unpack
    assign addr_arr[g]  = ch_addr_i[g*AW +: AW];
    assign wdata_arr[g] = ch_wdata_i[g*DW +: DW];
  end

  rr_arbiter #(
    .N_CH    (N_CH),
    .CH_BITS (CH_BITS)
  ) u_rr (
    .req_i (ch_req_i),
    .ptr_i (rr_q),
    .gnt_o (arb_gnt),
    .idx_o (arb_idx)
  );

  assign issue_rd = (state_q == S_ISSUE);

  // Only accept read data that lines up with one of our own issued reads, so a
  // return still in flight from before a reset can never be counted as a fill word.
  assign fill_strobe = mem_data_valid_i && pend_q[MEM_LAT-1] &&
                       ((state_q == S_ISSUE) || (state_q == S_DRAIN));

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    grant_d     = grant_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    issue_cnt_d = issue_cnt_q;
    recv_cnt_d  = recv_cnt_q + {{IDX_BITS{1'b0}}, fill_strobe};
    rr_d        = rr_q;
    pend_d      = (pend_q << 1) | MEM_LAT'(issue_rd);

    case (state_q)
      S_IDLE: begin
        recv_cnt_d = '0;
        if (|ch_req_i) begin
          grant_d     = arb_gnt;
          owner_d     = arb_idx;
          addr_d      = addr_arr[arb_idx];
          wdata_d     = wdata_arr[arb_idx];
          issue_cnt_d = '0;
          state_d     = ch_wr_i[arb_idx] ? S_WRITE : S_ISSUE;
        end
      end
      S_ISSUE: begin
        issue_cnt_d = issue_cnt_q + 1'b1;
        if (issue_cnt_q == ISSUE_LAST) state_d = S_DRAIN;
      end
      S_DRAIN: begin
        if (recv_cnt_d == RECV_FULL) state_d = S_DONE;
      end
      S_WRITE: begin
        state_d = S_DONE;
      end
      S_DONE: begin
        grant_d = '0;
        rr_d    = (owner_q == CH_BITS'(N_CH - 1)) ? '0 : owner_q + CH_BITS'(1);
        state_d = S_IDLE;
      end
      default: begin
        grant_d = '0;
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= S_IDLE;
      owner_q     <= '0;
      grant_q     <= '0;
      addr_q      <= '0;
      wdata_q     <= '0;
      issue_cnt_q <= '0;
      recv_cnt_q  <= '0;
      rr_q        <= '0;
      pend_q      <= '0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      grant_q     <= grant_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      issue_cnt_q <= issue_cnt_d;
      recv_cnt_q  <= recv_cnt_d;
      rr_q        <= rr_d;
      pend_q      <= pend_d;
    end
  end

  assign ch_grant_o      = grant_q;
  assign ch_busy_o       = (state_q != S_IDLE);
  assign ch_fill_valid_o = fill_strobe ? grant_q : '0;
  assign ch_fill_data_o  = fill_strobe ? mem_rdata_i : '0;
  assign ch_fill_idx_o   = recv_cnt_q[IDX_BITS-1:0];
  assign ch_done_o       = (state_q == S_DONE) ? grant_q : '0;

  assign mem_enable_o = (state_q == S_ISSUE) || (state_q == S_WRITE);
  assign mem_wr_o     = (state_q == S_WRITE);
  assign mem_wdata_o  = (state_q == S_WRITE) ? wdata_q : '0;

  always_comb begin
    mem_addr_o = '0;
    if (state_q == S_ISSUE)
      mem_addr_o = (addr_q & ~OFFS_MASK) | (AW'(issue_cnt_q) << WORD_SHIFT);
    else if (state_q == S_WRITE)
      mem_addr_o = addr_q;
  end

  a_valid_in_fill: assert property (@(posedge clk_i) disable iff (!rst_ni)
    mem_data_valid_i |-> ((state_q == S_ISSUE) || (state_q == S_DRAIN)));

endmodule

// File: tb/tb_mem_miss_arbiter.sv
// Directed checks of the miss arbiter: fills, writes, round-robin order, reset abort.
module tb_mem_miss_arbiter;

  localparam int MEM_LAT = 4;
  localparam int WORDS   = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // 2-channel DUT
  logic [1:0]  req = '0, wr = '0;
  logic [31:0] addr = '0, wdata = '0;
  logic [1:0]  grant, fill_valid, done;
  logic        busy, mem_en, mem_wr, mem_dv;
  logic [15:0] fill_data, mem_addr, mem_wdata, mem_rdata;
  logic [2:0]  fill_idx;

  mem_miss_arbiter #(.N_CH(2), .AW(16), .DW(16), .WORDS(WORDS), .MEM_LAT(MEM_LAT)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .ch_req_i(req), .ch_wr_i(wr), .ch_addr_i(addr), .ch_wdata_i(wdata),
    .ch_grant_o(grant), .ch_busy_o(busy), .ch_fill_valid_o(fill_valid),
    .ch_fill_data_o(fill_data), .ch_fill_idx_o(fill_idx), .ch_done_o(done),
    .mem_enable_o(mem_en), .mem_wr_o(mem_wr), .mem_addr_o(mem_addr),
    .mem_wdata_o(mem_wdata), .mem_rdata_i(mem_rdata), .mem_data_valid_i(mem_dv));

  // Fixed-latency read memory; word content is its address scrambled.
  logic [MEM_LAT-1:0] mv;
  logic [15:0]        ma [MEM_LAT];
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mv <= '0;
      for (int i = 0; i < MEM_LAT; i++) ma[i] <= '0;
    end else begin
      mv    <= {mv[MEM_LAT-2:0], mem_en && !mem_wr};
      ma[0] <= mem_addr;
      for (int i = 1; i < MEM_LAT; i++) ma[i] <= ma[i-1];
    end
  end
  assign mem_dv    = mv[MEM_LAT-1];
  assign mem_rdata = mv[MEM_LAT-1] ? (ma[MEM_LAT-1] ^ 16'hA5C3) : 16'h0000;

  // 4-channel DUT for pointer ordering
  logic [3:0]  req4 = '0, wr4 = '0;
  logic [63:0] addr4 = '0, wdata4 = '0;
  logic [3:0]  grant4, fill_valid4, done4;
  logic        busy4, mem_en4, mem_wr4;
  logic [15:0] fill_data4, mem_addr4, mem_wdata4;
  logic [15:0] mem_rdata4 = '0;
  logic        mem_dv4 = 1'b0;
  logic [1:0]  fill_idx4;

  mem_miss_arbiter #(.N_CH(4), .AW(16), .DW(16), .WORDS(4), .MEM_LAT(MEM_LAT)) dut4 (
    .clk_i(clk), .rst_ni(rst_n),
    .ch_req_i(req4), .ch_wr_i(wr4), .ch_addr_i(addr4), .ch_wdata_i(wdata4),
    .ch_grant_o(grant4), .ch_busy_o(busy4), .ch_fill_valid_o(fill_valid4),
    .ch_fill_data_o(fill_data4), .ch_fill_idx_o(fill_idx4), .ch_done_o(done4),
    .mem_enable_o(mem_en4), .mem_wr_o(mem_wr4), .mem_addr_o(mem_addr4),
    .mem_wdata_o(mem_wdata4), .mem_rdata_i(mem_rdata4), .mem_data_valid_i(mem_dv4));

  int n_chk  = 0;
  int n_fail = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Called in an idle cycle; runs one transaction on the 2-channel DUT.
  task automatic do_txn(input int ch, input logic is_wr, input logic [15:0] a,
                        input logic [15:0] d, input bit drop_req);
    logic [1:0]  oh;
    logic [15:0] base;
    int          n_iss, n_rcv;
    bit          done_seen;
    oh        = 2'b01 << ch;
    base      = a & 16'hFFF0;
    n_iss     = 0;
    n_rcv     = 0;
    done_seen = 1'b0;
    req[ch]            = 1'b1;
    wr[ch]             = is_wr;
    addr[ch*16 +: 16]  = a;
    wdata[ch*16 +: 16] = d;
    for (int k = 1; k <= 40 && !done_seen; k++) begin
      @(negedge clk);
      if (drop_req && k == 1) req[ch] = 1'b0;
      check("grant_hold", grant, oh);
      if (mem_en) begin
        if (is_wr) begin
          check("wr_cycle", k, 1);
          check("wr_flag", mem_wr, 1'b1);
          check("wr_addr", mem_addr, a);
          check("wr_data", mem_wdata, d);
        end else begin
          check("rd_flag", mem_wr, 1'b0);
          check("rd_addr", mem_addr, base + 16'(n_iss * 2));
          check("rd_cycle", k, n_iss + 1);
          n_iss++;
        end
      end
      if (|fill_valid) begin
        check("fill_valid", fill_valid, oh);
        check("fill_idx", fill_idx, n_rcv);
        check("fill_data", fill_data, (base + 16'(n_rcv * 2)) ^ 16'hA5C3);
        check("fill_lat", k, MEM_LAT + 1 + n_rcv);
        n_rcv++;
      end
      if (|done) begin
        check("done_vec", done, oh);
        check("done_lat", k, is_wr ? 2 : MEM_LAT + WORDS + 1);
        done_seen = 1'b1;
        req[ch]   = 1'b0;
      end
    end
    check("done_seen", done_seen, 1'b1);
    if (!is_wr) begin
      check("n_issued", n_iss, WORDS);
      check("n_recv", n_rcv, WORDS);
    end
    @(negedge clk);
    check("idle_after", {busy, grant}, 3'b000);
  endtask

  initial begin
    int seen;

    repeat (3) @(negedge clk);
    check("reset_outs", {grant, busy, fill_valid, fill_data, fill_idx, done,
                         mem_en, mem_wr, mem_addr, mem_wdata}, 64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Both channels request continuously from reset: strict alternation.
    req   = 2'b11;
    wr    = 2'b11;
    addr  = {16'h0020, 16'h0010};
    wdata = {16'h2222, 16'h1111};
    seen  = 0;
    for (int k = 0; k < 40 && seen < 4; k++) begin
      @(negedge clk);
      check("grant_1hot", 64'($onehot0(grant)), 64'd1);
      if (|done) begin
        check("alt_order", done, (seen % 2 == 0) ? 2'b01 : 2'b10);
        seen++;
        if (seen == 4) req = 2'b00;
      end
    end
    check("alt_count", seen, 4);
    @(negedge clk);

    do_txn(0, 1'b1, 16'h00A4, 16'hBEEF, 1'b0);
    do_txn(1, 1'b0, 16'h1236, 16'h0000, 1'b0);
    do_txn(0, 1'b0, 16'h8001, 16'h0000, 1'b1);

    // Reset mid-fill on ch1 at issue_cnt = 3.
    req[1] = 1'b1;
    wr[1]  = 1'b0;
    addr[31:16] = 16'h4448;
    for (int k = 1; k <= 4; k++) @(negedge clk);
    check("pre_rst_addr", mem_addr, 16'h4446);
    rst_n = 1'b0;
    #1;
    check("rst_outs", {grant, busy, fill_valid, fill_data, fill_idx, done,
                       mem_en, mem_wr, mem_addr, mem_wdata}, 64'd0);
    req   = 2'b11;
    wr    = 2'b11;
    addr  = {16'h0102, 16'h0100};
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("rst_no_done", done, 2'b00);
    end
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_grant", grant, 2'b01);
    seen = 0;
    for (int k = 0; k < 10 && seen == 0; k++) begin
      if (|done) begin
        check("post_rst_done", done, 2'b01);
        seen = 1;
        req  = 2'b00;
      end else begin
        @(negedge clk);
      end
    end
    check("post_rst_seen", seen, 1);
    @(negedge clk);

    // 4 channels: ch1 first moves the pointer to 2, then ch3 must beat ch1.
    wr4   = 4'hF;
    addr4 = {16'h0300, 16'h0000, 16'h0200, 16'h0000};
    req4  = 4'b0010;
    seen  = 0;
    for (int k = 0; k < 10 && seen == 0; k++) begin
      @(negedge clk);
      if (|done4) begin
        check("rr4_first", done4, 4'b0010);
        seen = 1;
        req4 = 4'b0000;
      end
    end
    check("rr4_first_seen", seen, 1);
    @(negedge clk);
    req4 = 4'b1010;
    seen = 0;
    @(negedge clk);
    check("rr4_grant", grant4, 4'b1000);
    for (int k = 0; k < 20 && seen < 2; k++) begin
      if (|done4) begin
        check("rr4_order", done4, (seen == 0) ? 4'b1000 : 4'b0010);
        seen++;
        req4 = req4 & ~done4;
      end
      @(negedge clk);
    end
    check("rr4_count", seen, 2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
